// File: rtl/bcd_to_binary.sv
// BCD-to-binary converter using reverse double-dabble, one shift per clock.
// Latency BIN_W+1 clocks from accept to done; start is ignored (not queued) while busy or in DONE.
module bcd_to_binary #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      bin_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int W_W   = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [W_W-1:0]   w_q;
  logic [W_W-1:0]   w_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             digit_bad;
  logic             last_iter;

  always_comb begin
    digit_bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) digit_bad = 1'b1;
    end
  end

  assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));

  // Shift first, then correct every BCD nibble of the shifted word in parallel.
  always_comb begin
    w_nxt = w_q >> 1;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_nxt[BIN_W + 4*d +: 4] >= 4'd8)
        w_nxt[BIN_W + 4*d +: 4] = w_nxt[BIN_W + 4*d +: 4] - 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = digit_bad ? S_DONE : S_SHIFT;
      S_SHIFT: if (last_iter) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_SHIFT);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_q     <= '0;
      cnt_q   <= '0;
      err     <= 1'b0;
      bin_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (digit_bad) begin
              err     <= 1'b1;
              bin_out <= '0;
            end else begin
              w_q   <= {bcd_in, {BIN_W{1'b0}}};
              cnt_q <= '0;
              err   <= 1'b0;
            end
          end
        end
        S_SHIFT: begin
          w_q   <= w_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) bin_out <= w_nxt[BIN_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Bench for bcd_to_binary: directed cases plus an exhaustive 000..999 sweep with random gaps and mid-conversion noise.
module tb_bcd_to_binary;
  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [11:0]       bcd_in = '0;
  logic              busy, done, err;
  logic [BIN_W-1:0]  bin_out;

  int tests = 0;
  int failed = 0;

  bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .err(err), .bin_out(bin_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal value of packed BCD, or invalid if any digit exceeds 9.
  function automatic bit ref_valid(input logic [11:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9);
  endfunction

  function automatic int unsigned ref_value(input logic [11:0] v);
    return 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
  endfunction

  function automatic logic [11:0] to_bcd(input int unsigned n);
    logic [11:0] r;
    r[11:8] = 4'((n / 100) % 10);
    r[7:4]  = 4'((n / 10) % 10);
    r[3:0]  = 4'(n % 10);
    return r;
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk("idle_quiet", 32'({busy, done}), 32'h0);
    end
  endtask

  // mode 0: quiet, 1: random bcd_in/start noise, 2: start with 12'h456 in cycles 3 and 10
  task automatic convert(input logic [11:0] v, input int mode);
    bit          ok;
    int unsigned val;
    ok  = ref_valid(v);
    val = ok ? ref_value(v) : 0;
    start  = 1'b1;
    bcd_in = v;
    tick();
    start = 1'b0;
    if (!ok) begin
      chk("inv_flags", 32'({busy, done, err}), 32'h3);
      chk("inv_bin", 32'(bin_out), 32'h0);
      tick();
      chk("inv_fall", 32'({busy, done, err}), 32'h1);
    end else begin
      for (int i = 0; i < BIN_W; i++) begin
        if (i > 0) tick();
        chk("busy_phase", 32'({busy, done}), 32'h2);
        if (mode == 1) begin
          bcd_in = 12'($urandom);
          start  = 1'($urandom_range(0, 1));
        end else if (mode == 2) begin
          start  = (i == 1 || i == 8);
          if (start) bcd_in = 12'h456;
        end
      end
      tick();
      chk("done_phase", 32'({busy, done, err}), 32'h2);
      chk("bin_out", 32'(bin_out), val);
      if (mode == 1) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      tick();
      chk("done_fall", 32'({busy, done}), 32'h0);
      chk("bin_hold", 32'(bin_out), val);
      start = 1'b0;
    end
  endtask

  initial begin
    // reset state
    reset_n = 1'b0;
    start   = 1'b1;
    bcd_in  = 12'h999;
    tick();
    tick();
    chk("reset_outs", 32'({busy, done, err}), 32'h0);
    chk("reset_bin", 32'(bin_out), 32'h0);
    start   = 1'b0;
    reset_n = 1'b1;
    idle(2);

    convert(12'h999, 0);
    convert(12'h000, 0);
    convert(12'h255, 0);
    convert(12'h512, 0);
    idle(1);
    convert(12'h1A3, 0);
    chk("inv_no_busy", 32'(busy), 32'h0);
    convert(12'h042, 0);
    convert(12'h123, 2);
    idle(3);

    // reset mid-conversion aborts without a done pulse
    start  = 1'b1;
    bcd_in = 12'h999;
    tick();
    start = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    chk("abort_outs", 32'({busy, done, err}), 32'h0);
    chk("abort_bin", 32'(bin_out), 32'h0);
    reset_n = 1'b1;
    idle(14);
    convert(12'h007, 0);

    // a few random invalid codes
    for (int k = 0; k < 8; k++) begin
      logic [11:0] bad;
      bad = 12'($urandom);
      bad[7:4] = 4'($urandom_range(10, 15));
      convert(bad, 0);
      idle($urandom_range(0, 1));
    end

    // exhaustive sweep with random gaps and mid-conversion noise
    for (int n = 0; n < 1000; n++) begin
      convert(to_bcd(n), 1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
